// File: rtl/gcd_fsmd.sv
// gcd_fsmd: GCD of two unsigned WIDTH-bit operands by repeated subtraction.
// The working registers are exported as a_out/b_out to an external magnitude
// comparator. Its altb/aeqb/agtb flags steer each CALC step.
// Handshake: start is accepted while ready=1, and done pulses with result valid.
// Optional build macro FLAG_CHECK_EN adds a comparator-flag one-hot check with a
// sticky err output. Without it, err is tied low and the flags are priority-decoded.
module gcd_fsmd #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             ready,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    input  logic             altb,
    input  logic             aeqb,
    input  logic             agtb,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, stateNext;
    logic [WIDTH-1:0] aReg, aNext;
    logic [WIDTH-1:0] bReg, bNext;
    logic [WIDTH-1:0] resultReg, resultNext;
    logic             doneReg, doneNext;

`ifdef FLAG_CHECK_EN
    logic             errReg, errNext;
`endif

    // State and datapath registers. Reset discards any computation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            aReg      <= '0;
            bReg      <= '0;
            resultReg <= '0;
            doneReg   <= 1'b0;
`ifdef FLAG_CHECK_EN
            errReg    <= 1'b0;
`endif
        end else begin
            state     <= stateNext;
            aReg      <= aNext;
            bReg      <= bNext;
            resultReg <= resultNext;
            doneReg   <= doneNext;
`ifdef FLAG_CHECK_EN
            errReg    <= errNext;
`endif
        end
    end

    // Next-state and datapath decode. Entering DONE raises the registered done pulse.
    always_comb begin
        stateNext  = state;
        aNext      = aReg;
        bNext      = bReg;
        resultNext = resultReg;
`ifdef FLAG_CHECK_EN
        errNext    = errReg;
`endif
        unique case (state)
            IDLE: begin
                if (start) begin
                    aNext = a_in;
                    bNext = b_in;
`ifdef FLAG_CHECK_EN
                    errNext = 1'b0;
`endif
                    if (a_in == '0 || b_in == '0) begin
                        // gcd(0,x)=x, and gcd(0,0)=0, so no iteration is needed.
                        resultNext = a_in | b_in;
                        stateNext  = DONE;
                    end else begin
                        stateNext = CALC;
                    end
                end
            end
            CALC: begin
`ifdef FLAG_CHECK_EN
                case ({altb, aeqb, agtb})
                    3'b010: begin
                        resultNext = aReg;
                        stateNext  = DONE;
                    end
                    3'b001: aNext = aReg - bReg;
                    3'b100: bNext = bReg - aReg;
                    default: begin
                        errNext    = 1'b1;
                        resultNext = '0;
                        stateNext  = DONE;
                    end
                endcase
`else
                // Priority decode. All-zero flags fall through to the altb branch.
                if (aeqb) begin
                    resultNext = aReg;
                    stateNext  = DONE;
                end else if (agtb) begin
                    aNext = aReg - bReg;
                end else begin
                    bNext = bReg - aReg;
                end
`endif
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
        doneNext = (stateNext == DONE);
    end

    // Output mapping. ready is the only combinational output.
    always_comb begin
        ready  = (state == IDLE);
        a_out  = aReg;
        b_out  = bReg;
        result = resultReg;
        done   = doneReg;
`ifdef FLAG_CHECK_EN
        err    = errReg;
`else
        err    = 1'b0;
`endif
    end

endmodule

// File: tb/tb_gcd_fsmd.sv
// tb_gcd_fsmd: directed bench for gcd_fsmd with a golden comparator on a_out/b_out.
// A Euclid-based model predicts the latency and result of each request.
// A negedge compare process checks ready/done/err/result on every cycle.
// Define FLAG_CHECK_EN to exercise the flag-violation path.
module tb_gcd_fsmd;

    localparam int unsigned WIDTH = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a_in = '0;
    logic [WIDTH-1:0] b_in = '0;
    logic             ready, done, err;
    logic [WIDTH-1:0] a_out, b_out, result;
    logic             altb, aeqb, agtb;
    logic             forceZero = 1'b0;
    bit               checkEn = 1'b0;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    // Golden comparator, with an override that drives all flags low.
    assign altb = forceZero ? 1'b0 : (a_out < b_out);
    assign aeqb = forceZero ? 1'b0 : (a_out == b_out);
    assign agtb = forceZero ? 1'b0 : (a_out > b_out);

    gcd_fsmd #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset), .start(start), .a_in(a_in), .b_in(b_in),
        .ready(ready), .a_out(a_out), .b_out(b_out),
        .altb(altb), .aeqb(aeqb), .agtb(agtb),
        .result(result), .done(done), .err(err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int unsigned mGcd(input int unsigned a, input int unsigned b);
        int unsigned x = a, y = b, t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Subtraction count equals the sum of Euclid quotients minus one.
    function automatic int unsigned mLat(input int unsigned a, input int unsigned b);
        int unsigned x, y, t, sum;
        if (a == 0 || b == 0) return 1;
        x = (a > b) ? a : b;
        y = (a > b) ? b : a;
        sum = 0;
        while (y != 0) begin
            sum += x / y;
            t = x % y;
            x = y;
            y = t;
        end
        return 1 + sum;
    endfunction

    bit               mBusy = 1'b0;
    bit               mZeroCase = 1'b0;
    bit               mErr = 1'b0;
    int unsigned      mCnt = 0;
    int unsigned      mLatV = 1;
    logic [WIDTH-1:0] mRes = '0, mPend = '0, mA = '0, mB = '0;

    // Model: track each accepted request by cycle count since the accepting edge.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mBusy = 1'b0;
            mRes  = '0;
            mErr  = 1'b0;
            mCnt  = 0;
        end else if (mBusy) begin
            if (mCnt == mLatV - 1) begin
                mBusy = 1'b0;
                mRes  = mPend;
            end else begin
                mCnt++;
`ifdef FLAG_CHECK_EN
                if (forceZero && !mZeroCase) begin
                    mLatV = mCnt + 1;
                    mPend = '0;
                    mErr  = 1'b1;
                end
`endif
            end
        end else if (start) begin
            mBusy     = 1'b1;
            mCnt      = 0;
            mA        = a_in;
            mB        = b_in;
            mZeroCase = (a_in == 0) || (b_in == 0);
            mLatV     = mLat(a_in, b_in);
            mPend     = WIDTH'(mGcd(a_in, b_in));
            mErr      = 1'b0;
        end
    end

    // Compare process: checks the DUT against the model on every falling edge.
    always @(negedge clk) begin
        if (checkEn && !reset) begin
            bit doneCycle;
            doneCycle = mBusy && (mCnt == mLatV - 1);
            check("ready", ready, !mBusy);
            check("done", done, doneCycle);
            check("err", err, mErr);
            if (!mBusy) check("result_hold", result, mRes);
            else if (doneCycle) check("result_done", result, mPend);
            if (mBusy && mCnt == 0) begin
                check("a_out_load", a_out, mA);
                check("b_out_load", b_out, mB);
            end
        end
    end

    task automatic runOp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input int expRes, input int expLat, input string tag);
        int n;
        @(negedge clk);
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            n++;
        end while (!done && n < 400);
        check({tag, "_latency"}, n, expLat);
        check({tag, "_result"}, result, expRes);
        @(negedge clk);
        check({tag, "_ready_after"}, ready, 1);
        check({tag, "_done_low"}, done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        #1 reset = 1'b1;
        #12 reset = 1'b0;
        @(negedge clk);
        check("rst_ready", ready, 1);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_a_out", a_out, 0);
        check("rst_b_out", b_out, 0);
        check("rst_err", err, 0);
        checkEn = 1'b1;

        runOp(8'd48, 8'd18, 6, 6, "g48_18");
        runOp(8'd13, 8'd13, 13, 2, "g13_13");
        runOp(8'd0, 8'd7, 7, 1, "g0_7");
        runOp(8'd0, 8'd0, 0, 1, "g0_0");
        runOp(8'd7, 8'd0, 7, 1, "g7_0");
        runOp(8'd255, 8'd1, 1, 256, "g255_1");

        // A second start issued during CALC must be ignored.
        @(negedge clk);
        a_in = 8'd100; b_in = 8'd75; start = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) begin a_in = 8'd9; b_in = 8'd3; end
            if (n == 3) start = 1'b0;
        end while (!done && n < 400);
        check("ignore_latency", n, 5);
        check("ignore_result", result, 25);
        @(negedge clk);
        check("ignore_ready_after", ready, 1);

        // An asynchronous reset in the middle of CALC discards the computation.
        @(negedge clk);
        a_in = 8'd200; b_in = 8'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("midcalc_busy", ready, 0);
        #2 reset = 1'b1;
        #2 reset = 1'b0;
        @(negedge clk);
        check("midrst_ready", ready, 1);
        check("midrst_result", result, 0);
        check("midrst_done", done, 0);

        runOp(8'd17, 8'd5, 1, 8, "g17_5");
        runOp(8'd5, 8'd17, 1, 8, "g5_17");

`ifdef FLAG_CHECK_EN
        // All-zero flags during CALC: error path with done pulse and zeroed result.
        @(negedge clk);
        a_in = 8'd48; b_in = 8'd18; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        forceZero = 1'b1;
        @(negedge clk);
        forceZero = 1'b0;
        check("flag_done", done, 1);
        check("flag_err", err, 1);
        check("flag_result", result, 0);
        @(negedge clk);
        check("flag_err_sticky", err, 1);
        check("flag_ready", ready, 1);
        runOp(8'd6, 8'd4, 2, 4, "g6_4");
        check("flag_err_cleared", err, 0);
`else
        check("err_tied_low", err, 0);
`endif

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
